// File: rtl/vend_txn_controller.sv
// Vending machine transaction sequencer: product select, coin credit, dispense,
// change/refund payout handshake and per-product stock bookkeeping.
module vend_txn_controller #(
  parameter int         PRICE0      = 15,
  parameter int         PRICE1      = 20,
  parameter int         PRICE2      = 25,
  parameter int         PRICE3      = 12,
  parameter logic [3:0] STOCK_INIT  = 4'd9,
  parameter int         MAX_AMOUNT  = 99,
  parameter int         TIMEOUT_CYC = 250_000_000,
  parameter int         SOLDOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       restock,
  input  logic       payout_ack,
  output logic [2:0] state_out,
  output logic [1:0] sel_product,
  output logic [7:0] price,
  output logic [7:0] amount,
  output logic       dispense,
  output logic       coin_reject,
  output logic       payout_valid,
  output logic [7:0] payout_amt,
  output logic [3:0] sold_out
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SOLDOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PAY      = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4,
    SOLDOUT  = 3'd5
  } state_t;

  state_t          state_reg;
  logic [1:0]      sel_reg;
  logic [7:0]      price_reg;
  logic [7:0]      amount_reg;
  logic            dispense_reg;
  logic            coin_reject_reg;
  logic            payout_valid_reg;
  logic [7:0]      payout_amt_reg;
  logic [TW-1:0]   timer_reg;
  logic [SW-1:0]   soldout_cnt_reg;
  logic [3:0]      stock_reg [4];

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 8'(PRICE0);
      2'd1:    price_of = 8'(PRICE1);
      2'd2:    price_of = 8'(PRICE2);
      default: price_of = 8'(PRICE3);
    endcase
  endfunction

  logic       is_sel;
  logic       is_coin;
  logic       is_cancel;
  logic [3:0] coin_val;
  logic [8:0] coin_sum;
  logic       coin_fits;
  logic [7:0] key_price;
  logic [3:0] key_stock;
  logic       timer_hit;
  logic       cancel_now;

  always_comb begin
    is_sel    = (key_code[3:2] == 2'b00);
    is_cancel = (key_code == 4'hF);
    case (key_code)
      4'hA:    coin_val = 4'd2;
      4'hB:    coin_val = 4'd5;
      4'hC:    coin_val = 4'd10;
      default: coin_val = 4'd0;
    endcase
    is_coin    = (coin_val != 4'd0);
    coin_sum   = {1'b0, amount_reg} + {5'd0, coin_val};
    coin_fits  = (coin_sum <= 9'(MAX_AMOUNT));
    key_price  = price_of(key_code[1:0]);
    key_stock  = stock_reg[key_code[1:0]];
    timer_hit  = (timer_reg == TW'(TIMEOUT_CYC - 1));
    // A key in the same cycle as the timeout takes precedence over it
    cancel_now = key_valid ? is_cancel : timer_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      sel_reg          <= 2'd0;
      price_reg        <= 8'd0;
      amount_reg       <= 8'd0;
      dispense_reg     <= 1'b0;
      coin_reject_reg  <= 1'b0;
      payout_valid_reg <= 1'b0;
      payout_amt_reg   <= 8'd0;
      timer_reg        <= '0;
      soldout_cnt_reg  <= '0;
      for (int i = 0; i < 4; i++) stock_reg[i] <= STOCK_INIT;
    end else begin
      dispense_reg    <= 1'b0;
      coin_reject_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (restock) begin
            for (int i = 0; i < 4; i++) stock_reg[i] <= STOCK_INIT;
          end
          if (key_valid && is_sel) begin
            if (key_stock != 4'd0) begin
              sel_reg    <= key_code[1:0];
              price_reg  <= key_price;
              amount_reg <= 8'd0;
              timer_reg  <= '0;
              state_reg  <= PAY;
            end else begin
              soldout_cnt_reg <= '0;
              state_reg       <= SOLDOUT;
            end
          end
        end

        PAY: begin
          // Compare uses the registered credit, so a sale starts one cycle after the last coin
          if (amount_reg >= price_reg) begin
            dispense_reg   <= 1'b1;
            payout_amt_reg <= amount_reg - price_reg;
            if (stock_reg[sel_reg] != 4'd0) begin
              stock_reg[sel_reg] <= stock_reg[sel_reg] - 4'd1;
            end
            state_reg <= DISPENSE;
          end else begin
            if (key_valid) timer_reg <= '0;
            else           timer_reg <= timer_reg + 1'b1;
            if (key_valid && is_coin) begin
              if (coin_fits) amount_reg      <= coin_sum[7:0];
              else           coin_reject_reg <= 1'b1;
            end else if (cancel_now) begin
              if (amount_reg != 8'd0) begin
                payout_valid_reg <= 1'b1;
                payout_amt_reg   <= amount_reg;
                state_reg        <= REFUND;
              end else begin
                price_reg <= 8'd0;
                state_reg <= IDLE;
              end
            end
          end
        end

        DISPENSE: begin
          amount_reg <= 8'd0;
          if (payout_amt_reg != 8'd0) begin
            payout_valid_reg <= 1'b1;
            state_reg        <= CHANGE;
          end else begin
            price_reg <= 8'd0;
            state_reg <= IDLE;
          end
        end

        CHANGE, REFUND: begin
          if (payout_ack && payout_valid_reg) begin
            payout_valid_reg <= 1'b0;
            payout_amt_reg   <= 8'd0;
            amount_reg       <= 8'd0;
            price_reg        <= 8'd0;
            state_reg        <= IDLE;
          end
        end

        SOLDOUT: begin
          if (soldout_cnt_reg == SW'(SOLDOUT_CYC - 1)) begin
            state_reg <= IDLE;
          end else begin
            soldout_cnt_reg <= soldout_cnt_reg + 1'b1;
          end
        end

        default: begin
          price_reg        <= 8'd0;
          amount_reg       <= 8'd0;
          payout_valid_reg <= 1'b0;
          payout_amt_reg   <= 8'd0;
          state_reg        <= IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sold_out
      assign sold_out[gi] = (stock_reg[gi] == 4'd0);
    end
  endgenerate

  assign state_out    = state_reg;
  assign sel_product  = sel_reg;
  assign price        = price_reg;
  assign amount       = amount_reg;
  assign dispense     = dispense_reg;
  assign coin_reject  = coin_reject_reg;
  assign payout_valid = payout_valid_reg;
  assign payout_amt   = payout_amt_reg;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: vector table for the basic flows,
// hand-written sequences for credit ceiling, stock depletion and timeout.
module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       restock;
  logic       payout_ack;
  logic [2:0] state_out;
  logic [1:0] sel_product;
  logic [7:0] price;
  logic [7:0] amount;
  logic       dispense;
  logic       coin_reject;
  logic       payout_valid;
  logic [7:0] payout_amt;
  logic [3:0] sold_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vend_txn_controller #(
    .PRICE0(15), .PRICE1(20), .PRICE2(99), .PRICE3(12),
    .STOCK_INIT(4'd9), .MAX_AMOUNT(99),
    .TIMEOUT_CYC(100), .SOLDOUT_CYC(20)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .restock(restock), .payout_ack(payout_ack), .state_out(state_out),
    .sel_product(sel_product), .price(price), .amount(amount),
    .dispense(dispense), .coin_reject(coin_reject), .payout_valid(payout_valid),
    .payout_amt(payout_amt), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       ack;
    logic [2:0] st;
    logic [7:0] amt;
    logic [7:0] pr;
    logic       disp;
    logic       rej;
    logic       pv;
    logic [7:0] pamt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic kv, logic [3:0] kc, logic ack, logic [2:0] st,
                             logic [7:0] amt, logic [7:0] pr, logic disp, logic rej,
                             logic pv, logic [7:0] pamt);
    vec_t r;
    r.kv = kv; r.kc = kc; r.ack = ack; r.st = st; r.amt = amt; r.pr = pr;
    r.disp = disp; r.rej = rej; r.pv = pv; r.pamt = pamt;
    return r;
  endfunction

  // {state, amount, price, dispense, coin_reject, payout_valid, payout_amt}
  function automatic logic [29:0] snap();
    return {state_out, amount, price, dispense, coin_reject, payout_valid, payout_amt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 4'd0; restock = 1'b0; payout_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(snap()), 32'd0);
    check("reset_sold_out", 32'(sold_out), 32'd0);
    reset = 1'b1;
    tick();

    // Product 1 (20): two 10-coins, exact price, no change
    vecs.push_back(v(1, 4'h1, 0, 3'd1,  0, 20, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hC, 0, 3'd1, 10, 20, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hC, 0, 3'd1, 20, 20, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'h0, 0, 3'd2, 20, 20, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'h0, 0, 3'd0,  0,  0, 0, 0, 0, 0));
    // Coin, cancel and ack are ignored in IDLE
    vecs.push_back(v(1, 4'hA, 0, 3'd0,  0,  0, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hF, 1, 3'd0,  0,  0, 0, 0, 0, 0));
    // Product 0 (15): pay 20, change 5, select key ignored in PAY, key ignored in CHANGE
    vecs.push_back(v(1, 4'h0, 0, 3'd1,  0, 15, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'h2, 0, 3'd1,  0, 15, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hC, 0, 3'd1, 10, 15, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hC, 0, 3'd1, 20, 15, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'h0, 0, 3'd2, 20, 15, 1, 0, 0, 5));
    vecs.push_back(v(0, 4'h0, 0, 3'd3,  0, 15, 0, 0, 1, 5));
    vecs.push_back(v(1, 4'hC, 0, 3'd3,  0, 15, 0, 0, 1, 5));
    vecs.push_back(v(0, 4'h0, 1, 3'd0,  0,  0, 0, 0, 0, 0));
    // Cancel with zero credit returns straight to IDLE
    vecs.push_back(v(1, 4'h1, 0, 3'd1,  0, 20, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hF, 0, 3'd0,  0,  0, 0, 0, 0, 0));
    // Product 2: coin 5 then cancel -> refund 5
    vecs.push_back(v(1, 4'h2, 0, 3'd1,  0, 99, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hB, 0, 3'd1,  5, 99, 0, 0, 0, 0));
    vecs.push_back(v(1, 4'hF, 0, 3'd4,  5, 99, 0, 0, 1, 5));

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid  = vecs[i].kv;
      key_code   = vecs[i].kc;
      payout_ack = vecs[i].ack;
      tick();
      key_valid  = 1'b0;
      payout_ack = 1'b0;
      check($sformatf("vec%0d", i), 32'(snap()),
            32'({vecs[i].st, vecs[i].amt, vecs[i].pr, vecs[i].disp, vecs[i].rej,
                 vecs[i].pv, vecs[i].pamt}));
    end

    // Refund request persists while the hopper has not acknowledged
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("refund_hold%0d", i), 32'({state_out, payout_valid, payout_amt}),
            32'({3'd4, 1'b1, 8'd5}));
    end
    payout_ack = 1'b1;
    tick();
    payout_ack = 1'b0;
    check("refund_ack", 32'(snap()), 32'd0);

    // Credit ceiling: 95 + 10 refused, then 2+2 lands exactly on 99
    press(4'h2);
    repeat (9) press(4'hC);
    press(4'hB);
    check("amount_95", 32'(amount), 32'd95);
    press(4'hC);
    check("reject_pulse", 32'({state_out, amount, coin_reject}), 32'({3'd1, 8'd95, 1'b1}));
    tick();
    check("reject_clear", 32'({amount, coin_reject}), 32'({8'd95, 1'b0}));
    press(4'hA);
    press(4'hA);
    check("amount_99", 32'({amount, coin_reject}), 32'({8'd99, 1'b0}));
    tick();
    check("dispense_99", 32'(snap()), 32'({3'd2, 8'd99, 8'd99, 1'b1, 1'b0, 1'b0, 8'd0}));
    tick();
    check("idle_after_99", 32'(snap()), 32'd0);

    // Deplete product 3
    for (int s = 0; s < 9; s++) begin
      press(4'h3);
      press(4'hC);
      press(4'hA);
      tick();
      check($sformatf("sale3_disp%0d", s), 32'(dispense), 32'd1);
      tick();
      check($sformatf("sale3_sold%0d", s), 32'(sold_out[3]), 32'(s == 8));
    end
    check("sold_out_vec", 32'(sold_out), 32'h8);
    press(4'h3);
    check("soldout_enter", 32'(state_out), 32'd5);
    repeat (19) tick();
    check("soldout_hold", 32'(state_out), 32'd5);
    tick();
    check("soldout_exit", 32'(state_out), 32'd0);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    check("restock", 32'(sold_out), 32'd0);
    press(4'h3);
    check("sel_after_restock", 32'({state_out, price, sel_product}), 32'({3'd1, 8'd12, 2'd3}));
    press(4'hF);
    check("cancel_after_restock", 32'(state_out), 32'd0);

    // Timeout: key arriving on the timeout cycle wins, then a real timeout refunds
    press(4'h1);
    press(4'hA);
    repeat (99) tick();
    check("timeout_edge_pay", 32'({state_out, amount}), 32'({3'd1, 8'd2}));
    press(4'hB);
    check("key_beats_timeout", 32'({state_out, amount}), 32'({3'd1, 8'd7}));
    repeat (99) tick();
    check("timeout_not_yet", 32'(state_out), 32'd1);
    tick();
    check("timeout_refund", 32'({state_out, payout_valid, payout_amt}), 32'({3'd4, 1'b1, 8'd7}));
    payout_ack = 1'b1;
    tick();
    payout_ack = 1'b0;
    check("timeout_ack", 32'(snap()), 32'd0);
    press(4'h1);
    repeat (100) tick();
    check("timeout_zero_credit", 32'({state_out, price}), 32'd0);

    // Asynchronous reset mid-transaction discards credit
    press(4'h1);
    press(4'hC);
    check("pre_reset_amount", 32'(amount), 32'd10);
    reset = 1'b0;
    #2;
    check("async_reset", 32'(snap()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    check("no_payout_after_reset", 32'(snap()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
